// File: rtl/wifi_at_sequencer_if.sv
// Byte-level bus between the AT sequencer and its command ROM / UART TX / UART RX engines.
// master = sequencer side, slave = ROM + UART side.
interface wifi_at_sequencer_if #(
  parameter int ROM_AW = 6
);
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              rx_valid;
  logic [7:0]        rx_data;

  modport master (
    output rom_addr, tx_data, tx_start,
    input  rom_data, tx_busy, rx_valid, rx_data
  );

  modport slave (
    input  rom_addr, tx_data, tx_start,
    output rom_data, tx_busy, rx_valid, rx_data
  );
endinterface

// File: rtl/wifi_at_sequencer.sv
// Wi-Fi module bring-up: pulses RST_WiFi, waits for boot, then streams LF-terminated AT
// commands from a synchronous ROM and waits for "OK" per command, retrying on "ER" or timeout.
module wifi_at_sequencer #(
  parameter int RST_PULSE_CYC    = 50000,
  parameter int BOOT_WAIT_CYC    = 25000000,
  parameter int RESP_TIMEOUT_CYC = 50000000,
  parameter int NUM_CMDS         = 4,
  parameter int MAX_RETRY        = 3,
  parameter int ROM_AW           = 6
) (
  input  logic                    iCLK,
  input  logic                    RST,
  input  logic                    start,
  output logic                    RST_WiFi,
  output logic [3:0]              cmd_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  wifi_at_sequencer_if.master     bus
);

  // One timer is shared by reset pulse, boot wait and response wait; it only ever counts to CYC-1.
  localparam int TMAX0 = (RST_PULSE_CYC > BOOT_WAIT_CYC) ? RST_PULSE_CYC : BOOT_WAIT_CYC;
  localparam int TMAX  = (TMAX0 > RESP_TIMEOUT_CYC) ? TMAX0 : RESP_TIMEOUT_CYC;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] T_RST  = TW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0] T_BOOT = TW'(BOOT_WAIT_CYC - 1);
  localparam logic [TW-1:0] T_RESP = TW'(RESP_TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);
  localparam logic [3:0]    N_CMD  = 4'(NUM_CMDS);
  localparam logic [7:0]    LF     = 8'h0A;

  typedef enum logic [3:0] {
    IDLE, RST_PULSE, BOOT_WAIT, FETCH, LOAD, SEND, WAIT_TX, WAIT_RESP, DONE, ERROR
  } state_t;

  state_t            state;
  logic [TW-1:0]     tmr;
  logic [RW-1:0]     retry_cnt;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [ROM_AW-1:0] cmd_base;
  logic [7:0]        tx_data_q;
  logic              tx_start_q;
  logic              tx_skip;
  logic [7:0]        prev;
  logic              resp_ok;
  logic              resp_fail;

  assign bus.rom_addr = rom_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

  // prev holds the byte before the current strobe, so "OK"/"ER" are two consecutive rx bytes.
  assign resp_ok   = bus.rx_valid && (prev == 8'h4F) && (bus.rx_data == 8'h4B);
  assign resp_fail = (bus.rx_valid && (prev == 8'h45) && (bus.rx_data == 8'h52)) || (tmr == T_RESP);

  always_ff @(posedge iCLK) begin
    if (RST) begin
      state      <= IDLE;
      tmr        <= '0;
      retry_cnt  <= '0;
      rom_addr_q <= '0;
      cmd_base   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tx_skip    <= 1'b0;
      prev       <= '0;
      RST_WiFi   <= 1'b1;
      cmd_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= RST_PULSE;
            RST_WiFi   <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cmd_idx    <= '0;
            rom_addr_q <= '0;
            cmd_base   <= '0;
            retry_cnt  <= '0;
            tmr        <= '0;
          end
        end
        RST_PULSE: begin
          if (tmr == T_RST) begin
            tmr      <= '0;
            RST_WiFi <= 1'b1;
            state    <= BOOT_WAIT;
          end else tmr <= tmr + 1'b1;
        end
        BOOT_WAIT: begin
          if (tmr == T_BOOT) begin
            tmr   <= '0;
            state <= FETCH;
          end else tmr <= tmr + 1'b1;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          tx_data_q <= bus.rom_data;
          state     <= SEND;
        end
        SEND: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_skip    <= 1'b1;
            state      <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // tx_busy only rises the cycle after tx_start, so the first cycle here is not trusted.
          if (tx_skip) tx_skip <= 1'b0;
          else if (!bus.tx_busy) begin
            rom_addr_q <= rom_addr_q + 1'b1;
            if (tx_data_q == LF) begin
              tmr   <= '0;
              prev  <= '0;
              state <= WAIT_RESP;
            end else state <= FETCH;
          end
        end
        WAIT_RESP: begin
          if (bus.rx_valid) prev <= bus.rx_data;
          if (resp_ok) begin
            tmr       <= '0;
            cmd_idx   <= cmd_idx + 4'd1;
            retry_cnt <= '0;
            cmd_base  <= rom_addr_q;
            if (cmd_idx + 4'd1 == N_CMD) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else state <= FETCH;
          end else if (resp_fail) begin
            tmr <= '0;
            if (retry_cnt == R_MAX) begin
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              retry_cnt  <= retry_cnt + 1'b1;
              rom_addr_q <= cmd_base;
              state      <= FETCH;
            end
          end else tmr <= tmr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wifi_at_sequencer.sv
// Directed bench for wifi_at_sequencer: synchronous ROM model, 10-cycle UART TX model, scripted rx replies.
module tb_wifi_at_sequencer;
  localparam int AW = 6;

  logic       iCLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       RST_WiFi;
  logic [3:0] cmd_idx;
  logic       busy, done, error;

  wifi_at_sequencer_if #(.ROM_AW(AW)) bus ();

  wifi_at_sequencer #(
    .RST_PULSE_CYC(4), .BOOT_WAIT_CYC(8), .RESP_TIMEOUT_CYC(100),
    .NUM_CMDS(2), .MAX_RETRY(2), .ROM_AW(AW)
  ) dut (
    .iCLK(iCLK), .RST(RST), .start(start), .RST_WiFi(RST_WiFi),
    .cmd_idx(cmd_idx), .busy(busy), .done(done), .error(error), .bus(bus)
  );

  always #5 iCLK = ~iCLK;

  localparam logic [63:0] CMD0 = 64'h41540D0A;
  localparam logic [63:0] CMD1 = 64'h415445300D0A;

  logic [7:0] rom [0:63];
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0] = 8'h41; rom[1] = 8'h54; rom[2] = 8'h0D; rom[3] = 8'h0A;
    rom[4] = 8'h41; rom[5] = 8'h54; rom[6] = 8'h45; rom[7] = 8'h30;
    rom[8] = 8'h0D; rom[9] = 8'h0A;
  end
  always @(posedge iCLK) bus.rom_data <= rom[bus.rom_addr];

  // UART TX model: busy for 10 cycles starting the cycle after tx_start; logs bytes and start times.
  int         cyc = 0;
  int         tx_cnt = 0;
  int         lf_cnt = 0;
  logic       ext_busy = 1'b0;
  logic [7:0] tx_q [$];
  int         tx_t [$];
  always @(posedge iCLK) begin
    cyc <= cyc + 1;
    if (bus.tx_start === 1'b1) begin
      tx_cnt <= 10;
      tx_q.push_back(bus.tx_data);
      tx_t.push_back(cyc);
      if (bus.tx_data == 8'h0A) lf_cnt <= lf_cnt + 1;
    end else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.tx_busy = (tx_cnt != 0) | ext_busy;

  int nchk = 0;
  int nfail = 0;
  int lf0 = 0;
  int q0 = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int from, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[55:0], tx_q[q0 + from + i]};
    return r;
  endfunction

  // Wait until the k-th LF of this run has left the transmitter; the DUT is then in WAIT_RESP.
  task automatic wait_lfs(input int k);
    int n = 0;
    while ((lf_cnt < lf0 + k || bus.tx_busy) && n < 3000) begin
      tick(1);
      n++;
    end
    chk($sformatf("lf%0d_wait", k), 64'(n < 3000), 64'd1);
    tick(2);
  endtask

  task automatic send_rx(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.rx_data  = s[i];
      bus.rx_valid = 1'b1;
      tick(1);
      bus.rx_valid = 1'b0;
      tick(2);
    end
  endtask

  task automatic new_run();
    lf0 = lf_cnt;
    q0  = tx_q.size();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rst_wifi"}, 64'(RST_WiFi), 64'd1);
    chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
    chk({tag, "_tx_data"}, 64'(bus.tx_data), 64'd0);
    chk({tag, "_tx_start"}, 64'(bus.tx_start), 64'd0);
    chk({tag, "_cmd_idx"}, 64'(cmd_idx), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic run_happy(input string tag);
    int low = 0;
    new_run();
    chk({tag, "_busy_on"}, 64'(busy), 64'd1);
    chk({tag, "_done_clr"}, 64'(done), 64'd0);
    for (int i = 0; i < 30; i++) begin
      if (RST_WiFi === 1'b0) low++;
      tick(1);
    end
    chk({tag, "_rst_low_cyc"}, 64'(low), 64'd4);
    wait_lfs(1);
    chk({tag, "_cmd0"}, pack(0, 4), CMD0);
    chk({tag, "_byte_gap"}, 64'(tx_t[q0 + 1] - tx_t[q0]), 64'd15);
    send_rx("OK");
    wait_lfs(2);
    chk({tag, "_cmd1"}, pack(4, 6), CMD1);
    send_rx("OK");
    tick(2);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_cmd_idx"}, 64'(cmd_idx), 64'd2);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_nbytes"}, 64'(tx_q.size() - q0), 64'd10);
  endtask

  initial begin
    int n;
    int pulses;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick(3);
    chk_reset("por");
    RST = 1'b0;
    tick(2);

    run_happy("happy");

    // No reply to the first attempt of cmd 0: timeout, resend after 100 cycles in WAIT_RESP.
    new_run();
    wait_lfs(1);
    wait_lfs(2);
    chk("to_retry_gap", 64'(tx_t[q0 + 4] - tx_t[q0 + 3]), 64'd115);
    chk("to_cmd0_again", pack(4, 4), CMD0);
    send_rx("OK");
    wait_lfs(3);
    chk("to_cmd1", pack(8, 6), CMD1);
    send_rx("OK");
    tick(2);
    chk("to_done", 64'(done), 64'd1);
    chk("to_cmd_idx", 64'(cmd_idx), 64'd2);

    // ERROR on every attempt of cmd 1: three sends, then error.
    new_run();
    wait_lfs(1);
    send_rx("OK");
    for (int a = 0; a < 3; a++) begin
      wait_lfs(2 + a);
      send_rx("ERROR\r\n");
    end
    tick(2);
    chk("err_error", 64'(error), 64'd1);
    chk("err_done", 64'(done), 64'd0);
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_cmd_idx", 64'(cmd_idx), 64'd1);
    chk("err_lf_count", 64'(lf_cnt - lf0), 64'd4);
    tick(40);
    chk("err_quiet", 64'(tx_q.size() - q0), 64'd22);

    // "OK" echoed while cmd 0 is still transmitting must not advance.
    new_run();
    chk("echo_err_clr", 64'(error), 64'd0);
    n = 0;
    while (tx_q.size() == q0 && n < 500) begin
      tick(1);
      n++;
    end
    send_rx("OK");
    wait_lfs(1);
    chk("echo_no_adv", 64'(cmd_idx), 64'd0);
    tick(20);
    chk("echo_still", 64'(cmd_idx), 64'd0);

    // Hold tx_busy externally so cmd 1's first byte stalls in SEND.
    ext_busy = 1'b1;
    send_rx("OK");
    chk("echo_real_ok", 64'(cmd_idx), 64'd1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.tx_start === 1'b1) pulses++;
      tick(1);
    end
    chk("hs_held", 64'(pulses), 64'd0);
    ext_busy = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_start === 1'b1) pulses++;
      tick(1);
    end
    chk("hs_one_pulse", 64'(pulses), 64'd1);
    wait_lfs(2);
    chk("hs_cmd1", pack(4, 6), CMD1);

    // In WAIT_RESP of cmd 1: start is ignored, RST aborts.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("ign_busy", 64'(busy), 64'd1);
    chk("ign_rst_wifi", 64'(RST_WiFi), 64'd1);
    chk("ign_cmd_idx", 64'(cmd_idx), 64'd1);
    RST = 1'b1;
    tick(1);
    chk_reset("mid");
    RST = 1'b0;
    tick(3);
    chk("mid_idle", 64'(busy), 64'd0);

    run_happy("rerun1");
    run_happy("rerun2");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/wifi_at_sequencer.md
Name: wifi_at_sequencer

Overview:
- Brings up the Wi-Fi module attached to the UART client after power-on or on request.
- Sequence: pulses RST_WiFi, waits for boot, then streams a fixed list of AT commands from an external command ROM through the shared UART transmitter.
- Waits for "OK" after each command; retries on timeout or "ER" (ERROR) response; reports done/error.
- Sits between the command ROM, the UART TX/RX byte engines and the UART client top level.

Parameters:
- RST_PULSE_CYC, 50000: cycles RST_WiFi is held low.
- BOOT_WAIT_CYC, 25000000: cycles waited after release before the first command.
- RESP_TIMEOUT_CYC, 50000000: cycles allowed per response.
- NUM_CMDS, 4: commands in ROM (1..15).
- MAX_RETRY, 3: retries per command after the first attempt.
- ROM_AW, 6: command ROM address width.

Ports:
- iCLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins the sequence
- RST_WiFi  out  1  Wi-Fi module reset, active-low
- rom_addr  out  ROM_AW  command ROM address
- rom_data  in  8  ROM byte; valid 1 cycle after rom_addr (synchronous ROM)
- tx_data  out  8  byte to UART TX
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  UART TX busy; rises the cycle after tx_start, falls when the stop bit ends
- rx_valid  in  1  one-cycle strobe, received byte
- rx_data  in  8  received byte
- cmd_idx  out  4  index of the command in progress / completed count
- busy  out  1  sequence running
- done  out  1  all commands acknowledged (level)
- error  out  1  retries exhausted (level)

Behaviour:
- Reset values: RST_WiFi=1, rom_addr=0, tx_data=0, tx_start=0, cmd_idx=0, busy=0, done=0, error=0; state IDLE; all counters 0. RST mid-sequence aborts at the next edge.
- ROM layout: commands concatenated. Each command ends with 0x0A (LF), which is transmitted. The next command starts at the following address.
- States: IDLE, RST_PULSE, BOOT_WAIT, FETCH, LOAD, SEND, WAIT_TX, WAIT_RESP, DONE, ERROR. busy=1 in every state except IDLE, DONE and ERROR.
- IDLE/DONE/ERROR:
  - start=1 -> RST_PULSE; clears done, error, cmd_idx, rom_addr, cmd_base, retry_cnt.
  - start is ignored in all other states.
- RST_PULSE: RST_WiFi=0 for exactly RST_PULSE_CYC cycles, then RST_WiFi=1 -> BOOT_WAIT.
- BOOT_WAIT: exactly BOOT_WAIT_CYC cycles -> FETCH.
- FETCH: drive rom_addr, 1 cycle -> LOAD. LOAD: capture rom_data into tx_data -> SEND.
- SEND: when tx_busy=0, assert tx_start for exactly 1 cycle -> WAIT_TX. tx_start never fires while tx_busy=1.
- WAIT_TX: ignore the first cycle, then wait for tx_busy=0.
  - If tx_data==0x0A: rom_addr+1, clear the response timer and match register -> WAIT_RESP.
  - Otherwise: rom_addr+1 -> FETCH.
- WAIT_RESP:
  - Timer increments each cycle.
  - Match register holds the previous rx byte; it is updated only on rx_valid.
  - Success: prev==0x4F ('O') and current==0x4B ('K').
  - Failure: prev==0x45 ('E') and current==0x52 ('R'), or timer==RESP_TIMEOUT_CYC-1.
  - Success and timeout in the same cycle: success wins.
  - On success: cmd_idx+1, retry_cnt=0, cmd_base=rom_addr. Go to DONE if the new cmd_idx==NUM_CMDS, else FETCH.
  - On failure: if retry_cnt==MAX_RETRY -> ERROR (cmd_idx holds the failing index). Otherwise retry_cnt+1, rom_addr=cmd_base -> FETCH.
- rx bytes arriving outside WAIT_RESP (module echo, boot banner) are ignored.
- DONE: done=1. ERROR: error=1. Both held until the next start or RST.
- Counters are sized with $clog2 of their maximum and never wrap.

Test Plan:
Bench parameters: RST_PULSE_CYC=4, BOOT_WAIT_CYC=8, RESP_TIMEOUT_CYC=100, NUM_CMDS=2, MAX_RETRY=2. ROM = 41 54 0D 0A 41 54 45 30 0D 0A. TX model: busy 10 cycles per byte.
- Happy path: start; reply "OK" after each LF -> RST_WiFi low exactly 4 cycles; tx bytes 41 54 0D 0A, then 41 54 45 30 0D 0A; done=1, cmd_idx=2, error=0.
- Timeout retry: no reply to cmd 0 on first attempt, then "OK" -> cmd 0 bytes sent twice, 100 cycles apart in WAIT_RESP; then cmd 1 sent; done=1.
- Error path: reply "ERROR\r\n" to every attempt of cmd 1 -> cmd 1 sent 3 times total; error=1, cmd_idx=1, done=0, busy=0.
- Echo ignored: inject "OK" while command bytes are still transmitting -> no advance; the later real "OK" advances cmd_idx.
- Handshake: hold tx_busy=1 externally for 30 cycles in SEND -> tx_start stays 0, then exactly one 1-cycle pulse after release.
- Mid-run reset: assert RST during WAIT_RESP of cmd 1 -> next cycle all outputs at reset values; start during busy ignored; start from DONE reruns the full sequence.
